// File: rtl/cont_desc_nbits_pkg.sv
// Shared definitions for the loadable down counter: default width and FSM state encoding.
package cont_desc_nbits_pkg;

  localparam int CONT_N_DEF = 4;

  // Encoding 2'd3 is unused; the FSM sends it back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/cont_desc_nbits_reg_carga.sv
// reg_carga: N-bit register with synchronous active-high reset and load enable.
import cont_desc_nbits_pkg::*;

module reg_carga #(
  parameter int N = CONT_N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] val_q, val_d;

  // Next value: capture d on ld, otherwise hold.
  always_comb begin
    val_d = val_q;
    if (ld) begin
      val_d = d;
    end else begin
      val_d = val_q;
    end
  end

  // Storage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/cont_desc_nbits.sv
// Loadable N-bit down counter with terminal count. Macro AUTO_RELOAD_EN selects
// periodic reload at end of count; undefined gives one-shot behaviour ending in DONE.
import cont_desc_nbits_pkg::*;

module cont_desc_nbits #(
  parameter int N = CONT_N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic         TC,
  output logic         done
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] reload_q;
  logic         reload_ld_s;
  logic         tc_s;

  reg_carga #(.N(N)) u_reg_carga (
    .clk   (clk),
    .reset (reset),
    .ld    (reload_ld_s),
    .d     (D),
    .q     (reload_q)
  );

  // Next-state, next-count and terminal-count decode.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    reload_ld_s = 1'b0;
    tc_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          q_d         = D;
          reload_ld_s = 1'b1;
          state_d     = ST_COUNT;
        end else begin
          q_d = q_q;
        end
      end
      ST_COUNT: begin
        // A load wins over enable: no decrement and no TC from the old value.
        if (load) begin
          q_d         = D;
          reload_ld_s = 1'b1;
        end else if (enable) begin
          if (q_q == '0) begin
            tc_s = 1'b1;
`ifdef AUTO_RELOAD_EN
            q_d = reload_q;
`else
            q_d     = '0;
            state_d = ST_DONE;
`endif
          end else begin
            q_d = q_q - ONE;
          end
        end else begin
          q_d = q_q;
        end
      end
      ST_DONE: begin
        if (load) begin
          q_d         = D;
          reload_ld_s = 1'b1;
          state_d     = ST_COUNT;
        end else begin
          q_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
    end
  end

`ifndef AUTO_RELOAD_EN
  // The reload value is only consumed in auto-reload builds.
  logic unused_reload_s;
  assign unused_reload_s = ^reload_q;
`endif

  assign Q    = q_q;
  assign TC   = tc_s;
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_cont_desc_nbits.sv
// Self-checking bench for cont_desc_nbits (N=4): vector table, hand sequences and
// randomized stimulus against a behavioural model of the counter.
module tb_cont_desc_nbits;

  logic       clk = 1'b0;
  logic       rst_i, en_i, ld_i;
  logic [3:0] d_i;
  logic [3:0] Q;
  logic       TC, done;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: 0 = idle, 1 = counting, 2 = finished
  int m_q, m_rl, m_st;
  int obs_q, obs_tc, obs_done;

  cont_desc_nbits #(.N(4)) dut (
    .clk    (clk),
    .reset  (rst_i),
    .enable (en_i),
    .load   (ld_i),
    .D      (d_i),
    .Q      (Q),
    .TC     (TC),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit l, input int dv);
    int m_tc;
    rst_i = r;
    en_i  = e;
    ld_i  = l;
    d_i   = 4'(dv);
    @(negedge clk);
    m_tc = (m_st == 1 && e && !l && m_q == 0) ? 1 : 0;
    obs_q    = int'(Q);
    obs_tc   = int'(TC);
    obs_done = int'(done);
    check("model_q", obs_q, m_q);
    check("model_tc", obs_tc, m_tc);
    check("model_done", obs_done, (m_st == 2) ? 1 : 0);
    @(posedge clk);
    if (r) begin
      m_q = 0; m_rl = 0; m_st = 0;
    end else if (l && m_st <= 2) begin
      m_q = dv; m_rl = dv; m_st = 1;
    end else if (m_st == 1 && e) begin
      if (m_q == 0) begin
`ifdef AUTO_RELOAD_EN
        m_q = m_rl;
`else
        m_st = 2;
`endif
      end else begin
        m_q = m_q - 1;
      end
    end
    #1;
  endtask

  typedef struct {
    bit r, e, l;
    int d;
    int q, tc, dn;
  } vec_t;

  vec_t vt[11];

  initial begin
    int tc_cnt;
    vt[0]  = '{1'b1, 1'b0, 1'b1, 3, 0, 0, 0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 5, 0, 0, 0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 0, 5, 0, 0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 0, 4, 0, 0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 0, 3, 0, 0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 0, 2, 0, 0};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 0, 1, 0, 0};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 0, 0, 1, 0};
`ifdef AUTO_RELOAD_EN
    vt[9]  = '{1'b0, 1'b1, 1'b0, 0, 5, 0, 0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 0, 4, 0, 0};
`else
    vt[9]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 1};
    vt[10] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 1};
`endif

    // Reset with enable and load both asserted; model starts in its reset state
    m_q = 0; m_rl = 0; m_st = 0;
    rst_i = 1'b1; en_i = 1'b1; ld_i = 1'b1; d_i = 4'd9;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      cycle(vt[i].r, vt[i].e, vt[i].l, vt[i].d);
      check($sformatf("vec%0d_q", i), obs_q, vt[i].q);
      check($sformatf("vec%0d_tc", i), obs_tc, vt[i].tc);
      check($sformatf("vec%0d_done", i), obs_done, vt[i].dn);
    end

    // Load D=3 then 12 enabled cycles: periodic TC only with auto-reload
    cycle(1'b0, 1'b0, 1'b1, 3);
    tc_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 0);
      tc_cnt += obs_tc;
    end
`ifdef AUTO_RELOAD_EN
    check("reload_tc_count", tc_cnt, 3);
    check("reload_done", obs_done, 0);
`else
    check("oneshot_tc_count", tc_cnt, 1);
    check("oneshot_done", obs_done, 1);
`endif

    // Load together with enable while counting at Q=2
    cycle(1'b0, 1'b0, 1'b1, 4);
    cycle(1'b0, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b1, 9);
    check("load_vs_en_pre_q", obs_q, 2);
    check("load_vs_en_tc", obs_tc, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);
    check("load_vs_en_next_q", obs_q, 9);

    // Load of zero gives TC on the first enabled cycle, then random enable
    cycle(1'b0, 1'b0, 1'b1, 0);
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("load0_tc", obs_tc, 1);
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 1'($urandom % 2), 1'b0, 0);
    end

    // Reset in the middle of a count
    cycle(1'b0, 1'b0, 1'b1, 6);
    cycle(1'b0, 1'b0, 1'b0, 0);
    check("pre_reset_q", obs_q, 6);
    cycle(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 0);
      check("post_reset_q", obs_q, 0);
      check("post_reset_tc", obs_tc, 0);
      check("post_reset_done", obs_done, 0);
    end

    // Fully random traffic
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom % 32) == 0, 1'($urandom % 2), ($urandom % 6) == 0,
            int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
